// File: rtl/wordle_pkg.sv
// +--------------------------------------------------------------------+
// | wordle_pkg : shared score codes, letter bounds and state encoding  |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
`default_nettype none

package wordle_pkg;

  localparam logic [1:0] SCORE_BLANK  = 2'b00;
  localparam logic [1:0] SCORE_GRAY   = 2'b01;
  localparam logic [1:0] SCORE_YELLOW = 2'b10;
  localparam logic [1:0] SCORE_GREEN  = 2'b11;

  localparam int LETTER_A = 0;
  localparam int LETTER_Z = 25;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_EVAL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/wordle_scorer.sv
// +--------------------------------------------------------------------+
// | wordle_scorer : one-cycle green pass, then one yellow step/letter  |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
`default_nettype none

module wordle_scorer
  import wordle_pkg::*;
#(
  parameter int WORD_LEN = 5,
  parameter int LETTER_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic [WORD_LEN*LETTER_W-1:0] i_guess,
  input  logic [WORD_LEN*LETTER_W-1:0] i_secret,
  output logic                         o_done,
  output logic [2*WORD_LEN-1:0]        o_scores,
  output logic                         o_all_green
);

  localparam int IDX_W = $clog2(WORD_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);

  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_GREEN  = 2'd1;
  localparam logic [1:0] PH_YELLOW = 2'd2;

  logic [1:0]            phase_q, phase_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_LEN-1:0]   used_q, used_d;
  logic [2*WORD_LEN-1:0] score_q, score_d;
  logic                  found;

  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    used_d  = used_q;
    score_d = score_q;
    found   = 1'b0;
    o_done  = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        if (i_start) phase_d = PH_GREEN;
      end
      PH_GREEN: begin
        for (int i = 0; i < WORD_LEN; i++) begin
          if (i_guess[i*LETTER_W +: LETTER_W] == i_secret[i*LETTER_W +: LETTER_W]) begin
            score_d[2*i +: 2] = SCORE_GREEN;
            used_d[i]         = 1'b1;
          end else begin
            score_d[2*i +: 2] = SCORE_BLANK;
            used_d[i]         = 1'b0;
          end
        end
        idx_d   = '0;
        phase_d = PH_YELLOW;
      end
      PH_YELLOW: begin
        // Only the letter at idx_q is resolved; it claims the lowest unused match.
        for (int i = 0; i < WORD_LEN; i++) begin
          if (IDX_W'(i) == idx_q && score_q[2*i +: 2] != SCORE_GREEN) begin
            score_d[2*i +: 2] = SCORE_GRAY;
            found             = 1'b0;
            for (int j = 0; j < WORD_LEN; j++) begin
              if (!found && !used_q[j] &&
                  i_secret[j*LETTER_W +: LETTER_W] == i_guess[i*LETTER_W +: LETTER_W]) begin
                found             = 1'b1;
                used_d[j]         = 1'b1;
                score_d[2*i +: 2] = SCORE_YELLOW;
              end
            end
          end
        end
        if (idx_q == LAST_IDX) begin
          o_done  = 1'b1;
          phase_d = PH_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  always_comb begin
    o_scores    = score_d;
    o_all_green = 1'b1;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (score_d[2*i +: 2] != SCORE_GREEN) o_all_green = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      idx_q   <= '0;
      used_q  <= '0;
      score_q <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      used_q  <= used_d;
      score_q <= score_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wordle_game_engine.sv
// +--------------------------------------------------------------------+
// | wordle_game_engine : letter entry, guess counting and scoring FSM  |
// | Optional macro WORDLE_HARD_MODE_EN adds green-lock guess rejection |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
`default_nettype none

module wordle_game_engine
  import wordle_pkg::*;
#(
  parameter int WORD_LEN    = 5,
  parameter int MAX_GUESSES = 6,
  parameter int LETTER_W    = 5
) (
  input  logic                               Clk,
  input  logic                               reset,
  input  logic                               Start,
  input  logic                               Ack,
  input  logic                               U,
  input  logic                               D,
  input  logic                               L,
  input  logic                               R,
  input  logic                               C,
  input  logic [WORD_LEN*LETTER_W-1:0]       secret_word,
  output logic [WORD_LEN*LETTER_W-1:0]       cur_word,
  output logic [$clog2(WORD_LEN)-1:0]        cursor,
  output logic [2*WORD_LEN-1:0]              score_flat,
  output logic                               score_valid,
  output logic [$clog2(MAX_GUESSES+1)-1:0]   guess_count,
  output logic                               win,
`ifdef WORDLE_HARD_MODE_EN
  output logic                               reject_pulse,
`endif
  output logic                               q_I,
  output logic                               q_Entry,
  output logic                               q_Eval,
  output logic                               q_Done
);

  localparam int CUR_W  = $clog2(WORD_LEN);
  localparam int GC_W   = $clog2(MAX_GUESSES + 1);
  localparam int WORD_W = WORD_LEN * LETTER_W;
  localparam logic [CUR_W-1:0]    LAST_POS = CUR_W'(WORD_LEN - 1);
  localparam logic [LETTER_W-1:0] L_A      = LETTER_W'(LETTER_A);
  localparam logic [LETTER_W-1:0] L_Z      = LETTER_W'(LETTER_Z);
  localparam logic [GC_W-1:0]     GC_MAX   = GC_W'(MAX_GUESSES);

  logic [1:0]            state_q, state_d;
  logic [WORD_W-1:0]     secret_q, secret_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [CUR_W-1:0]      cursor_q, cursor_d;
  logic [2*WORD_LEN-1:0] score_q, score_d;
  logic                  score_valid_q, score_valid_d;
  logic [GC_W-1:0]       gc_q, gc_d;
  logic                  win_q, win_d;

  logic                  sc_start, sc_done, sc_all_green;
  logic [2*WORD_LEN-1:0] sc_scores;
  logic                  guess_bad;
  logic                  letter_we;
  logic [LETTER_W-1:0]   cur_letter, new_letter;

  always_comb begin
    cur_letter = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (CUR_W'(i) == cursor_q) cur_letter = word_q[i*LETTER_W +: LETTER_W];
    end
  end

  always_comb begin
    state_d       = state_q;
    secret_d      = secret_q;
    word_d        = word_q;
    cursor_d      = cursor_q;
    score_d       = score_q;
    score_valid_d = 1'b0;
    gc_d          = gc_q;
    win_d         = win_q;
    sc_start      = 1'b0;
    letter_we     = 1'b0;
    new_letter    = cur_letter;
    case (state_q)
      S_INIT: begin
        if (Start) begin
          secret_d = secret_word;
          state_d  = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (C) begin
          if (!guess_bad) begin
            gc_d     = gc_q + 1'b1;
            sc_start = 1'b1;
            state_d  = S_EVAL;
          end
        end else if (U) begin
          letter_we  = 1'b1;
          new_letter = (cur_letter == L_Z) ? L_A : cur_letter + 1'b1;
        end else if (D) begin
          letter_we  = 1'b1;
          new_letter = (cur_letter == L_A) ? L_Z : cur_letter - 1'b1;
        end else if (L) begin
          cursor_d = (cursor_q == '0) ? LAST_POS : cursor_q - 1'b1;
        end else if (R) begin
          cursor_d = (cursor_q == LAST_POS) ? '0 : cursor_q + 1'b1;
        end
      end
      S_EVAL: begin
        if (sc_done) begin
          score_d       = sc_scores;
          score_valid_d = 1'b1;
          if (sc_all_green) begin
            win_d   = 1'b1;
            state_d = S_DONE;
          end else if (gc_q == GC_MAX) begin
            win_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d  = S_ENTRY;
            word_d   = '0;
            cursor_d = '0;
          end
        end
      end
      S_DONE: begin
        if (Ack) begin
          state_d  = S_INIT;
          secret_d = '0;
          word_d   = '0;
          cursor_d = '0;
          score_d  = '0;
          gc_d     = '0;
          win_d    = 1'b0;
        end
      end
      default: state_d = S_INIT;
    endcase
    if (letter_we) begin
      for (int i = 0; i < WORD_LEN; i++) begin
        if (CUR_W'(i) == cursor_q) word_d[i*LETTER_W +: LETTER_W] = new_letter;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q       <= S_INIT;
      secret_q      <= '0;
      word_q        <= '0;
      cursor_q      <= '0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      gc_q          <= '0;
      win_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      secret_q      <= secret_d;
      word_q        <= word_d;
      cursor_q      <= cursor_d;
      score_q       <= score_d;
      score_valid_q <= score_valid_d;
      gc_q          <= gc_d;
      win_q         <= win_d;
    end
  end

  // The guess under test stays frozen in word_q for the whole evaluation.
  wordle_scorer #(
    .WORD_LEN (WORD_LEN),
    .LETTER_W (LETTER_W)
  ) u_scorer (
    .clk         (Clk),
    .rst         (reset),
    .i_start     (sc_start),
    .i_guess     (word_q),
    .i_secret    (secret_q),
    .o_done      (sc_done),
    .o_scores    (sc_scores),
    .o_all_green (sc_all_green)
  );

`ifdef WORDLE_HARD_MODE_EN
  logic [WORD_LEN-1:0] lock_q, lock_d;
  logic [WORD_W-1:0]   lock_letter_q, lock_letter_d;
  logic                reject_q, reject_d;

  always_comb begin
    lock_d        = lock_q;
    lock_letter_d = lock_letter_q;
    guess_bad     = 1'b0;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (lock_q[i] && lock_letter_q[i*LETTER_W +: LETTER_W] != word_q[i*LETTER_W +: LETTER_W])
        guess_bad = 1'b1;
    end
    reject_d = (state_q == S_ENTRY) && C && guess_bad;
    if (state_q == S_INIT) begin
      lock_d        = '0;
      lock_letter_d = '0;
    end else if (state_q == S_EVAL && sc_done) begin
      for (int i = 0; i < WORD_LEN; i++) begin
        if (sc_scores[2*i +: 2] == SCORE_GREEN) begin
          lock_d[i]                              = 1'b1;
          lock_letter_d[i*LETTER_W +: LETTER_W] = word_q[i*LETTER_W +: LETTER_W];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      lock_q        <= '0;
      lock_letter_q <= '0;
      reject_q      <= 1'b0;
    end else begin
      lock_q        <= lock_d;
      lock_letter_q <= lock_letter_d;
      reject_q      <= reject_d;
    end
  end

  assign reject_pulse = reject_q;
`else
  assign guess_bad = 1'b0;
`endif

  assign cur_word    = word_q;
  assign cursor      = cursor_q;
  assign score_flat  = score_q;
  assign score_valid = score_valid_q;
  assign guess_count = gc_q;
  assign win         = win_q;
  assign q_I         = (state_q == S_INIT);
  assign q_Entry     = (state_q == S_ENTRY);
  assign q_Eval      = (state_q == S_EVAL);
  assign q_Done      = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: doc/wordle_game_engine.md
Name: wordle_game_engine

Overview:
- Parametrised successor to the fixed six-guess Wordle state machine. Generalises word length and guess limit.
- Owns letter entry from the debounced button pulses, the cursor, the guess counter and a multi-cycle scorer with correct duplicate-letter handling.
- Sits between the debouncer outputs and the VGA/LED output logic in the Wordle top.
- Exposes per-letter scores and win/lose status.

Parameters:
- WORD_LEN, 5: letters per word, from 2 to 8.
- MAX_GUESSES, 6: guesses allowed per game, from 1 to 15.
- LETTER_W, 5: bits per letter code. Code 0 is 'A' and code 25 is 'Z'.

Ports:
- Clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  single-cycle pulse; begins a game from INIT.
- Ack  in  1  single-cycle pulse; returns from DONE to INIT.
- U, D, L, R, C  in  1 each  debounced single-cycle button pulses.
- secret_word  in  WORD_LEN*LETTER_W  target word. Position 0 is in the LSBs. Sampled on Start.
- cur_word  out  WORD_LEN*LETTER_W  word currently being entered.
- cursor  out  clog2(WORD_LEN)  index of the letter being edited.
- score_flat  out  2*WORD_LEN  score of the last evaluated guess. Codes: 00 blank, 01 gray, 10 yellow, 11 green.
- score_valid  out  1  one-cycle pulse when score_flat updates.
- guess_count  out  clog2(MAX_GUESSES+1)  number of guesses submitted.
- win  out  1  last guess matched the secret.
- q_I, q_Entry, q_Eval, q_Done  out  1 each  one-hot state flags.

Behaviour:
- Reset, and also entry into INIT: the state is INIT; cur_word is all 'A' (0); cursor is 0; score_flat is 0; score_valid is 0; guess_count is 0; win is 0. The latched secret is cleared.
- INIT:
  - Start → ENTRY on the next edge. The secret is latched on that edge.
  - All other inputs are ignored.
- ENTRY: at most one button acts per cycle. Priority is C > U > D > L > R.
  - U: letter at cursor +1. 25 wraps to 0.
  - D: letter at cursor −1. 0 wraps to 25.
  - L: cursor −1. 0 wraps to WORD_LEN−1.
  - R: cursor +1. WORD_LEN−1 wraps to 0.
  - C: submit. guess_count increments and the state goes to EVAL.
  - Start and Ack are ignored.
- EVAL: multi-cycle, with all buttons ignored.
  - Cycle 0, green pass: each position whose guess letter equals the secret letter is scored green and marked used.
  - Cycles 1..WORD_LEN, yellow pass: one guess position i per cycle, i ascending. A non-green letter i scores yellow if some secret position j is unused and matches. The lowest such j is then marked used. Otherwise letter i scores gray.
  - Total latency from the C edge to the score_valid pulse is WORD_LEN+1 cycles.
  - score_valid is asserted for one cycle. score_flat holds its value until the next evaluation or INIT.
- After EVAL:
  - All letters green: win=1, go to DONE.
  - Otherwise, if guess_count==MAX_GUESSES: win=0, go to DONE.
  - Otherwise go to ENTRY. cur_word resets to all 'A', cursor to 0, and score_flat is kept.
- DONE:
  - Ack → INIT.
  - Start is ignored.
  - win, guess_count and score_flat hold.
- Start and Ack asserted together are each judged only in their own state.
- reset in any state, including mid-EVAL, returns to the reset values on the next edge. No partial score is emitted.

Optional Feature:
- Macro: WORDLE_HARD_MODE_EN.
- Defined:
  - A green-lock register holds, per position, a lock bit plus a letter. It is updated from every evaluated guess and cleared in INIT.
  - On C, if any locked position holds a different letter, the guess is rejected.
  - On rejection: reject_pulse (an extra 1-bit output) is high for one cycle; the state stays ENTRY; guess_count, cur_word and cursor are unchanged.
- Undefined: every submitted guess is accepted, and no reject_pulse port exists.

Decomposition:
- Package wordle_pkg holds:
  - score codes: SCORE_BLANK, SCORE_GRAY, SCORE_YELLOW, SCORE_GREEN;
  - LETTER_A = 0 and LETTER_Z = 25;
  - the state encoding: S_INIT, S_ENTRY, S_EVAL, S_DONE.
- Sub-module wordle_scorer:
  - Contains the green and yellow passes.
  - Handshake: start pulse in; done pulse, scores and all_green out.
  - Parameterised by WORD_LEN and LETTER_W.

Test Plan:
- Secret "APPLE". Start, then U/R sequences to enter "APPLE", then C → score_valid 6 cycles after C; all codes 11; win=1; q_Done; guess_count=1. Then Ack → q_I, guess_count=0.
- Secret "APPLE", guess "PAPAL" → score_flat pos0..4 = 10,10,11,01,10. Duplicate A scores gray; state returns to ENTRY.
- In ENTRY: L at cursor 0 → cursor 4. D on 'A' → 25. U on 'Z' → 0. U+L same cycle → only the letter increments.
- Six wrong guesses with MAX_GUESSES=6 → after the 6th score_valid: q_Done, win=0, guess_count=6. C in DONE is ignored.
- reset asserted 2 cycles into EVAL → next cycle q_I, score_valid never pulses, all outputs at reset values.
- With WORDLE_HARD_MODE_EN, "PAPAL" then a guess with pos2='A' → reject_pulse=1, guess_count stays 1, state is ENTRY.
